// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates an instruction-fetch port and a load/store port
// onto one shared single-cycle-latency memory port.
// Optional feature macro: MEM_ARB_RR_EN (round-robin contention instead of
// data-first priority with fetch-starvation override).
module mem_port_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   if_wins;

`ifdef MEM_ARB_RR_EN
    logic if_turn, if_turn_nxt;
`else
    localparam int unsigned SW = 2;
    localparam logic [SW-1:0] STARVE_MAX = SW'(3);
    logic [SW-1:0] starve_cnt, starve_cnt_nxt;
`endif

    // State register: read owner plus contention-resolution state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
`ifdef MEM_ARB_RR_EN
            if_turn <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
`ifdef MEM_ARB_RR_EN
            if_turn <= if_turn_nxt;
`else
            starve_cnt <= starve_cnt_nxt;
`endif
        end
    end

    // Grant decision, memory port steering, next read owner and read return
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        state_nxt = IDLE;

`ifdef MEM_ARB_RR_EN
        if_wins     = if_turn;
        if_turn_nxt = if_turn;
`else
        if_wins        = (starve_cnt == STARVE_MAX);
        starve_cnt_nxt = '0;
`endif

        if (!rst) begin
            if (if_req && d_req) begin
                if_gnt = if_wins;
                d_gnt  = ~if_wins;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end

        if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            state_nxt = RD_IF;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
            state_nxt = d_we ? IDLE : RD_D;
        end

`ifdef MEM_ARB_RR_EN
        // Loser of this contention gets the next one
        if (if_req && d_req) begin
            if_turn_nxt = d_gnt;
        end
`else
        if (if_req && !if_gnt) begin
            starve_cnt_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt
                                                         : starve_cnt + SW'(1);
        end
`endif

        // A read in flight is dropped if reset arrives before its return
        if_rvalid = (state == RD_IF) && !rst;
        d_rvalid  = (state == RD_D) && !rst;
        if_rdata  = if_rvalid ? mem_rdata : DW'(0);
        d_rdata   = d_rvalid  ? mem_rdata : DW'(0);

        stall = (if_req && !if_gnt) || (d_req && !d_gnt);
    end

    localparam logic [BW-1:0] BE_UNUSED = '0;
    // Keeps BW referenced for byte-enable sizing consistency
    if (BW != 4 || BE_UNUSED != 4'h0) begin : g_bw_check
        $error("mem_port_arb: byte-enable width must be 4");
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed + randomized self-checking bench for mem_port_arb.
module tb_mem_port_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        stall;

    int errors = 0;
    int checks = 0;

    mem_port_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: consecutive fetch losses, whose turn it is, and which
    // requester (0 none, 1 fetch, 2 data) is owed read data next cycle.
    int m_starve = 0;
    bit m_turn_if = 1'b0;
    int m_pend = 0;
    bit m_valid = 1'b0;

    logic        e_ig, e_dg, e_en, e_we, e_iv, e_dv, e_stall, contend;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    logic [3:0]  e_be;

    always @(negedge clk) begin
        contend = if_req && d_req;
        if (rst) begin
            e_ig = 1'b0; e_dg = 1'b0;
        end else if (contend) begin
`ifdef MEM_ARB_RR_EN
            e_ig = m_turn_if;
`else
            e_ig = (m_starve >= 3);
`endif
            e_dg = !e_ig;
        end else begin
            e_ig = if_req; e_dg = d_req;
        end

        e_en = e_ig || e_dg;
        e_we = e_dg && d_we;
        e_addr = e_ig ? if_addr : (e_dg ? d_addr : 32'h0);
        e_wdata = e_dg ? d_wdata : 32'h0;
        e_be = e_dg ? d_be : 4'h0;
        e_iv = !rst && (m_pend == 1);
        e_dv = !rst && (m_pend == 2);
        e_ird = e_iv ? mem_rdata : 32'h0;
        e_drd = e_dv ? mem_rdata : 32'h0;
        e_stall = (if_req && !e_ig) || (d_req && !e_dg);

        if (m_valid) begin
            chk("if_gnt", if_gnt, e_ig);
            chk("d_gnt", d_gnt, e_dg);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_be", mem_be, e_be);
            chk("if_rvalid", if_rvalid, e_iv);
            chk("d_rvalid", d_rvalid, e_dv);
            chk("if_rdata", if_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);
            chk("stall", stall, e_stall);
        end

        if (rst) begin
            m_pend = 0; m_starve = 0; m_turn_if = 1'b0; m_valid = 1'b1;
        end else begin
            m_pend = e_ig ? 1 : ((e_dg && !d_we) ? 2 : 0);
            m_starve = (if_req && !e_ig) ? ((m_starve < 3) ? m_starve + 1 : 3) : 0;
            if (contend) m_turn_if = e_dg;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_if_win;
    logic       g_i, g_d;

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h8; d_wdata = 32'h0; d_be = 4'h0; mem_rdata = 32'h0;
`ifdef MEM_ARB_RR_EN
        exp_if_win = 5'b01010;
`else
        exp_if_win = 5'b01000;
`endif
        // grants forced low during reset
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        cyc(); cyc();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("post_rst_if_rvalid", if_rvalid, 0);
        chk("post_rst_d_rvalid", d_rvalid, 0);

        // fetch only
        cyc(); if_req = 1'b1; if_addr = 32'h0000_0010;
        @(negedge clk);
        chk("fetch_gnt", if_gnt, 1);
        chk("fetch_mem_addr", mem_addr, 32'h10);
        chk("fetch_mem_en", mem_en, 1);
        cyc(); if_req = 1'b0; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("fetch_rvalid", if_rvalid, 1);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);

        // store
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        @(negedge clk);
        chk("store_gnt", d_gnt, 1);
        chk("store_mem_we", mem_we, 1);
        chk("store_mem_be", mem_be, 32'hF);
        chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("store_no_rvalid", d_rvalid, 0);
        chk("store_rdata_zero", d_rdata, 0);

        // contention for 5 cycles, data loads re-requesting each cycle
        for (int k = 0; k < 5; k++) begin
            cyc(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
            @(negedge clk);
            chk($sformatf("cont_if_gnt_%0d", k), if_gnt, exp_if_win[k]);
            chk($sformatf("cont_d_gnt_%0d", k), d_gnt, !exp_if_win[k]);
            chk($sformatf("cont_stall_%0d", k), stall, 1);
        end
        cyc(); if_req = 1'b0; d_req = 1'b0;

        // back-to-back load then fetch
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        chk("b2b_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h20; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("b2b_d_rvalid", d_rvalid, 1);
        chk("b2b_d_rdata", d_rdata, 32'h1111_2222);
        chk("b2b_if_gnt", if_gnt, 1);
        chk("b2b_if_rvalid_early", if_rvalid, 0);
        cyc(); if_req = 1'b0; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("b2b_if_rvalid", if_rvalid, 1);
        chk("b2b_if_rdata", if_rdata, 32'h3333_4444);
        chk("b2b_d_rvalid_done", d_rvalid, 0);

        // reset while a fetch read is in flight
        cyc(); if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        chk("rstmid_if_gnt", if_gnt, 1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rstmid_gnt_forced", if_gnt, 0);
        chk("rstmid_mem_en", mem_en, 0);
        chk("rstmid_no_rvalid", if_rvalid, 0);
        cyc(); rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("rstmid_after_rvalid", if_rvalid, 0);

        // randomized traffic; requesters hold until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g_i = if_gnt; g_d = d_gnt;
            cyc();
            if (g_i) if_req = 1'b0;
            if (g_d) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) != 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            mem_rdata = $urandom;
        end

        cyc(); rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have port clk, input, 1, core clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have ports if_req (in, 1), if_addr (in, 32): instruction-fetch read request and word address.
REQ-004 SHALL have ports if_gnt (out, 1), if_rvalid (out, 1), if_rdata (out, 32): fetch grant, read-data valid, read data.
REQ-005 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_be (in, 4): load/store request, write enable, address, write data, byte enables.
REQ-006 SHALL have ports d_gnt (out, 1), d_rvalid (out, 1), d_rdata (out, 32): data grant, load-data valid, load data.
REQ-007 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_be (out, 4): single shared memory port; memory reads return on mem_rdata (in, 32) exactly 1 cycle after mem_en=1, mem_we=0.
REQ-008 SHALL have port stall (out, 1): high when any request is present and not granted in that cycle.

Function
REQ-009 SHALL grant at most one requester per cycle; if_gnt and d_gnt SHALL be combinational from requests and registered arbitration state, never both 1.
REQ-010 SHALL drive mem_* from the granted requester in the grant cycle; mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-011 Read grant in cycle N SHALL produce the matching rvalid=1 with rdata=mem_rdata in cycle N+1, for exactly one cycle; a store SHALL produce no rvalid.
REQ-012 SHALL track the outstanding read owner in a registered state machine: IDLE (no read in flight), RD_IF (fetch read in flight), RD_D (load read in flight).
REQ-013 Transitions: any state -> RD_IF on fetch grant; -> RD_D on data read grant; -> IDLE on store grant or no grant.
REQ-014 SHALL allow a new grant in the same cycle as a previous read's rvalid (back-to-back, 1 request/cycle throughput).
REQ-015 if_rdata and d_rdata SHALL be zero when their rvalid is 0.
REQ-016 Requesters SHALL hold req and payload stable until granted; arbiter SHALL sample payload only in the grant cycle.
REQ-017 stall = (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-018 SHALL maintain a 2-bit saturating fetch-starvation counter: increments each cycle if_req=1 and if_gnt=0, clears on if_gnt or if_req=0; at value 3 fetch SHALL win the next contention.

Reset
REQ-019 While rst=1 at a clock edge: state=IDLE, starvation counter=0, priority pointer=data-first; in the cycle after, if_rvalid=d_rvalid=0.
REQ-020 A read in flight when rst is asserted SHALL be dropped: no rvalid is issued for it.
REQ-021 Grants during a cycle where rst=1 SHALL be forced to 0 and mem_en=0.

Configuration
REQ-022 Macro MEM_ARB_RR_EN: when defined, contention SHALL be resolved round-robin (1-bit last-winner register; loser of the previous contention wins next), starvation counter SHALL be omitted.
REQ-023 Without MEM_ARB_RR_EN: fixed priority, data over fetch, with REQ-018 starvation override.

Verification
REQ-024 Fetch only: if_req=1, if_addr=0x00000010, mem_rdata=0x00500093 next cycle -> if_gnt=1 cycle N, mem_addr=0x10, if_rvalid=1, if_rdata=0x00500093 cycle N+1.
REQ-025 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b1111 -> d_gnt=1, mem_we=1, mem_be=4'hF same cycle; d_rvalid stays 0 next cycle.
REQ-026 Contention, macro off: if_req=d_req=1 (load) for 5 cycles, data re-requesting each cycle -> d_gnt cycles 0-2, if_gnt cycle 3 (counter=3), stall=1 in every cycle with a loser.
REQ-027 Contention, MEM_ARB_RR_EN defined: both requesting continuously -> grants alternate D, IF, D, IF starting with D after reset.
REQ-028 Back-to-back: load grant cycle N, fetch grant cycle N+1 -> d_rvalid cycle N+1, if_rvalid cycle N+2, rdata routed to correct requester.
REQ-029 Reset mid-read: fetch granted cycle N, rst=1 at edge ending cycle N -> if_rvalid=0 in cycle N+1, all grants 0 while rst=1.
